// File: rtl/fired_tag_fifo.sv
// Firing-order tag queue between the neuron update stage and the synaptic
// processing unit, with a per-timestep fired bitmap that drops duplicate pushes.
module fired_tag_fifo #(
    parameter int numneurons = 2,
    parameter int tagbits    = 1
) (
    input  logic               clk,
    input  logic               asyn_reset,
    input  logic               req_enq,
    input  logic [tagbits-1:0] enq_tag,
    input  logic               clear_fired,
    input  logic               req_deq,
    output logic               fifo_empty,
    output logic               fifo_full,
    output logic [tagbits-1:0] src_tag_out,
    output logic [tagbits:0]   count,
    output logic               dup_drop,
    output logic               overflow,
    output logic               underflow
);

    localparam logic [tagbits:0] depth = (tagbits + 1)'(numneurons);

    logic [tagbits-1:0]    mem_reg [numneurons];
    logic [tagbits-1:0]    wr_ptr_reg;
    logic [tagbits-1:0]    rd_ptr_reg;
    logic [tagbits:0]      count_reg;
    logic [numneurons-1:0] fired_reg;
    logic [numneurons-1:0] fired_next;
    logic                  dup_drop_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;

    logic dup;
    logic deq_ok;
    logic push;

    assign fifo_empty  = (count_reg == '0);
    assign fifo_full   = (count_reg == depth);
    assign src_tag_out = fifo_empty ? '0 : mem_reg[rd_ptr_reg];
    assign count       = count_reg;
    assign dup_drop    = dup_drop_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;

    // clear_fired makes the bitmap lookup miss, so a repeat neuron can fire
    // again on the very first cycle of a new timestep.
    assign dup    = fired_reg[enq_tag] && !clear_fired;
    assign deq_ok = req_deq && !fifo_empty;
    assign push   = req_enq && !dup && (!fifo_full || deq_ok);

    genvar gi;
    generate
        for (gi = 0; gi < numneurons; gi++) begin : g_fired
            localparam logic [tagbits-1:0] bit_tag = tagbits'(gi);
            assign fired_next[gi] = (push && enq_tag == bit_tag) ? 1'b1
                                  : (clear_fired ? 1'b0 : fired_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= enq_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            fired_reg     <= '0;
            dup_drop_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            // Pointer width equals tagbits and depth is 2**tagbits, so the
            // natural roll-over is the wrap from numneurons-1 to 0.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (deq_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !deq_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push && deq_ok) begin
                count_reg <= count_reg - 1'b1;
            end
            fired_reg    <= fired_next;
            dup_drop_reg <= req_enq && dup;
            if (req_enq && !dup && fifo_full && !deq_ok) begin
                overflow_reg <= 1'b1;
            end
            if (req_deq && fifo_empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fired_tag_fifo.sv
// Directed bench for fired_tag_fifo: stimulus queues expected heads, a monitor
// checks each presented head when it is popped.
module tb_fired_tag_fifo;

    localparam int numneurons = 2;
    localparam int tagbits    = 1;

    logic               clk = 1'b0;
    logic               asyn_reset = 1'b1;
    logic               req_enq = 1'b0;
    logic [tagbits-1:0] enq_tag = '0;
    logic               clear_fired = 1'b0;
    logic               req_deq = 1'b0;
    logic               fifo_empty;
    logic               fifo_full;
    logic [tagbits-1:0] src_tag_out;
    logic [tagbits:0]   count;
    logic               dup_drop;
    logic               overflow;
    logic               underflow;

    int n_cmp = 0;
    int n_bad = 0;
    logic [tagbits-1:0] exp_q [$];

    fired_tag_fifo #(.numneurons(numneurons), .tagbits(tagbits)) dut (
        .clk         (clk),
        .asyn_reset  (asyn_reset),
        .req_enq     (req_enq),
        .enq_tag     (enq_tag),
        .clear_fired (clear_fired),
        .req_deq     (req_deq),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .src_tag_out (src_tag_out),
        .count       (count),
        .dup_drop    (dup_drop),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end else begin
            $display("ok   %s = %0d", name, actual);
        end
    endtask

    // Inputs are applied just after a rising edge, held across one edge, then released.
    task automatic step(input logic e, input int t, input logic d, input logic c);
        req_enq     = e;
        enq_tag     = tagbits'(t);
        req_deq     = d;
        clear_fired = c;
        @(posedge clk);
        #1;
        req_enq     = 1'b0;
        enq_tag     = '0;
        req_deq     = 1'b0;
        clear_fired = 1'b0;
    endtask

    // Monitor: an accepted pop consumes the presented head.
    always @(negedge clk) begin
        if (!asyn_reset && req_deq && !fifo_empty) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_head: got %0d, expected no entry", src_tag_out);
            end else begin
                automatic logic [tagbits-1:0] e = exp_q.pop_front();
                if (src_tag_out !== e) begin
                    n_bad++;
                    $display("FAIL pop_head: got %0d, expected %0d", src_tag_out, e);
                end else begin
                    $display("ok   pop_head = %0d", src_tag_out);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int wrap_tags [5] = '{1, 0, 1, 1, 0};

        // Reset
        asyn_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        asyn_reset = 1'b0;
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_count", count, 0);
        check("rst_src", src_tag_out, 0);
        check("rst_dup", dup_drop, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);

        // Basic push 1, 0 then pop twice
        step(1, 1, 0, 0); exp_q.push_back(1);
        check("p1_count", count, 1);
        check("p1_src", src_tag_out, 1);
        check("p1_empty", fifo_empty, 0);
        step(1, 0, 0, 0); exp_q.push_back(0);
        check("p2_count", count, 2);
        check("p2_full", fifo_full, 1);
        check("p2_src", src_tag_out, 1);
        step(0, 0, 1, 0);
        check("pop1_count", count, 1);
        check("pop1_src", src_tag_out, 0);
        step(0, 0, 1, 0);
        check("pop2_empty", fifo_empty, 1);
        check("pop2_count", count, 0);

        // Duplicate suppression
        step(0, 0, 0, 1);
        step(1, 1, 0, 0); exp_q.push_back(1);
        check("dupA_count", count, 1);
        check("dupA_drop", dup_drop, 0);
        step(1, 1, 0, 0);
        check("dupB_drop", dup_drop, 1);
        check("dupB_count", count, 1);
        step(0, 0, 0, 0);
        check("dupB_pulse_end", dup_drop, 0);
        step(0, 0, 0, 1);
        step(1, 1, 0, 0); exp_q.push_back(1);
        check("dupC_count", count, 2);
        check("dupC_drop", dup_drop, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("dup_drain", count, 0);

        // Full FIFO: simultaneous push/pop, then overflow
        step(0, 0, 0, 1);
        step(1, 0, 0, 0); exp_q.push_back(0);
        step(1, 1, 0, 0); exp_q.push_back(1);
        check("full_before", fifo_full, 1);
        step(1, 0, 1, 1); exp_q.push_back(0);
        check("full_pp_count", count, 2);
        check("full_pp_head", src_tag_out, 1);
        check("full_pp_ovf", overflow, 0);
        step(1, 1, 0, 0);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 2);
        check("ovf_dup", dup_drop, 0);
        step(0, 0, 0, 0);
        check("ovf_sticky", overflow, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("full_drain", fifo_empty, 1);
        check("unf_still_clear", underflow, 0);

        // Push and pop while empty
        step(1, 0, 1, 1); exp_q.push_back(0);
        check("emp_pp_count", count, 1);
        check("emp_pp_head", src_tag_out, 0);
        check("emp_pp_unf", underflow, 1);
        step(0, 0, 1, 0);
        check("emp_pp_drain", count, 0);

        // Pointer wrap
        foreach (wrap_tags[i]) begin
            step(1, wrap_tags[i], 0, 1); exp_q.push_back(tagbits'(wrap_tags[i]));
            check($sformatf("wrap%0d_count", i), count, 1);
            check($sformatf("wrap%0d_head", i), src_tag_out, wrap_tags[i]);
            step(0, 0, 1, 0);
        end
        check("wrap_empty", fifo_empty, 1);

        // Reset mid-operation
        step(0, 0, 0, 1);
        step(1, 0, 0, 0); exp_q.push_back(0);
        step(1, 1, 0, 0); exp_q.push_back(1);
        check("pre_rst_count", count, 2);
        asyn_reset = 1'b1;
        step(1, 0, 0, 0);
        asyn_reset = 1'b0;
        exp_q.delete();
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", fifo_empty, 1);
        check("mid_rst_full", fifo_full, 0);
        check("mid_rst_src", src_tag_out, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_unf", underflow, 0);
        check("mid_rst_dup", dup_drop, 0);
        step(1, 0, 0, 0); exp_q.push_back(0);
        check("post_rst_push", count, 1);
        check("post_rst_dup", dup_drop, 0);
        step(0, 0, 1, 0);
        check("final_empty", fifo_empty, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fired_tag_fifo.md
# fired_tag_fifo

Buffers the tags of neurons that fired during the current timestep and serves them, in firing order, to `synaptic_processing_unit` through its `fifo_empty` / `req_deq` / `src_tag_in` interface. The neuron update stage pushes tags on the write side. A per-neuron fired bitmap suppresses duplicate pushes within a timestep, so a depth of `numneurons` never overflows in correct operation. Sticky error flags record protocol violations for debug.

## Interface
- `numneurons`, 2, neuron count and FIFO depth; must equal 2**`tagbits`
- `tagbits`, 1, tag width; also the read/write pointer width
- `clk`  in  1  system clock; all state updates on the rising edge
- `asyn_reset`  in  1  reset, synchronous and active-high, sampled on the `clk` rising edge
- `req_enq`  in  1  push request from the neuron update stage
- `enq_tag`  in  `tagbits`  tag of the firing neuron
- `clear_fired`  in  1  one-cycle pulse at timestep start; clears the fired bitmap
- `req_deq`  in  1  pop request from `synaptic_processing_unit`
- `fifo_empty`  out  1  high when count == 0
- `fifo_full`  out  1  high when count == `numneurons`
- `src_tag_out`  out  `tagbits`  head entry (first-word fall-through); 0 when empty
- `count`  out  `tagbits`+1  number of stored entries
- `dup_drop`  out  1  one-cycle pulse: the previous cycle's push was rejected as a duplicate
- `overflow`  out  1  sticky: a push was rejected because the FIFO was full
- `underflow`  out  1  sticky: `req_deq` was asserted while the FIFO was empty

## Operation
- Storage: `numneurons` × `tagbits` register array, `wr_ptr`, `rd_ptr`, `count`, and a `numneurons`-bit fired bitmap.
- Push acceptance, evaluated per cycle: `req_enq` && !dup && (!`fifo_full` || `deq_ok`).
  - dup = `fired[enq_tag]` && !`clear_fired`.
  - `deq_ok` = `req_deq` && !`fifo_empty`.
- On an accepted push: `mem[wr_ptr]` <= `enq_tag`; `wr_ptr` increments and wraps from `numneurons`-1 to 0; `fired[enq_tag]` <= 1.
- On a pop (`deq_ok`): `rd_ptr` increments with the same wrap.
- `count` update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Rejected duplicate: no state change except `dup_drop` = 1 for the next cycle.
- Rejected full push (full with no pop in the same cycle): `overflow` <= 1, held until reset.
- `req_deq` while empty: ignored, no pointer change, `underflow` <= 1 (sticky).
- Push and pop while empty: the push is accepted and the pop is ignored (no bypass), so `count` becomes 1. `underflow` is set.
- Push and pop while full: both are accepted and `count` stays at `numneurons`.
- `clear_fired`: the bitmap becomes all zero, except the bit of a push accepted in the same cycle, which is set. Queue contents and pointers are unaffected.
- `synaptic_processing_unit` samples the head one cycle before it asserts `req_deq`. The head must stay stable until it is popped; only a pop changes `rd_ptr`.

## Timing
- Reset values: pointers 0, `count` 0, bitmap 0, `fifo_empty` 1, `fifo_full` 0, `src_tag_out` 0, `dup_drop` 0, `overflow` 0, `underflow` 0. Reset overrides all other inputs in that cycle.
- Reset mid-operation discards all queued tags. All outputs equal their reset values in the cycle after the reset edge.
- `fifo_empty`, `fifo_full`, `count` and `src_tag_out` are decoded from registers only; no input-to-output combinational path.
- Push latency: a push accepted at edge N gives `fifo_empty` = 0 and valid `src_tag_out` after edge N.
- Pop latency: a pop at edge N presents the next head (or empty) after edge N.
- Throughput: one push and one pop per cycle.

## Test plan
- Reset, then push tags 1 and 0 on consecutive cycles -> `count` goes 1 then 2, `src_tag_out` = 1, `fifo_full` = 1. Pop twice -> `src_tag_out` shows 1, then 0, then `fifo_empty` = 1, `count` = 0.
- Push tag 1, then tag 1 again -> second push rejected, `dup_drop` pulses one cycle, `count` stays 1. Pulse `clear_fired`, push tag 1 -> accepted, `count` = 2.
- Full FIFO (tags 0, 1): push and pop in the same cycle with `clear_fired` -> `count` stays 2, head becomes 1, tail holds the new tag. Push without pop -> `overflow` = 1 and remains set.
- Empty FIFO: `req_deq` = 1 with `req_enq` = 1, tag 0 -> `count` = 1, head = 0, `underflow` = 1.
- Pointer wrap: 5 push/pop pairs with `clear_fired` between them -> head sequence matches push order across the pointer wrap, with no loss.
- Reset asserted with 2 entries queued and `req_enq` high -> after the edge, `count` = 0, `fifo_empty` = 1, all flags 0, bitmap clear (a subsequent push of tag 0 is accepted).
